// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side SRAM-like bus: requester IDs,
// transfer size encodings and the arbiter state type.
package cpu_bus_pkg;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// Tag FIFO remembering which requester issued each accepted request, so
// in-order responses can be routed back. One bit per entry.
module arb_tag_fifo
    import cpu_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head_id,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] tags;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = tags[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer, count and tag storage update; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                tags[wr_ptr] <= push_id;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the instruction-fetch and load/store SRAM-like ports onto one
// memory port. Data side wins ties; a grant stalled by the slave is
// locked to its owner until addr_ok. Responses return in order and are
// steered by a tag FIFO.
module sram_like_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state;
    arb_state_t state_n;
    logic       owner_q;
    logic       owner;
    logic       owner_req;
    logic       fire;
    logic       fifo_pop;
    logic       fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    // In IDLE the owner is picked combinationally; once locked it is frozen.
    assign owner     = (state == ARB_LOCKED) ? owner_q
                     : (data_req ? REQ_DATA : REQ_INST);
    assign owner_req = (owner == REQ_DATA) ? data_req : inst_req;
    assign fire      = mem_req && mem_addr_ok;
    // A response with nothing outstanding is a slave error and is dropped.
    assign fifo_pop  = mem_data_ok && !fifo_empty && !reset;

    // State register, plus capture of the owner while a grant is still open.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB_IDLE;
            owner_q <= REQ_INST;
        end else begin
            state <= state_n;
            if (state == ARB_IDLE) begin
                owner_q <= owner;
            end
        end
    end

    // Next state: lock when the slave stalls a request, release on acceptance.
    always_comb begin
        state_n = state;
        case (state)
            ARB_IDLE:   if (mem_req && !mem_addr_ok) state_n = ARB_LOCKED;
            ARB_LOCKED: if (fire)                    state_n = ARB_IDLE;
            default:    state_n = ARB_IDLE;
        endcase
    end

    // Outputs: gated request, owner field mux, handshake and response routing.
    always_comb begin
        mem_req      = owner_req && !fifo_full && !reset;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_wstrb    = 4'd0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (mem_req) begin
            if (owner == REQ_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_wstrb = inst_wstrb;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
        inst_addr_ok = fire && (owner == REQ_INST);
        data_addr_ok = fire && (owner == REQ_DATA);
        inst_data_ok = fifo_pop && (fifo_head == REQ_INST);
        data_data_ok = fifo_pop && (fifo_head == REQ_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    arb_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fire),
        .push_id (owner),
        .pop     (fifo_pop),
        .head_id (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU's instruction fetch port (inst_*) and its load/store port (data_*).
- The memory port is the future single bus, ahead of the AXI bridge.
- Arbitrates each request, holds the grant until addr_ok, and keeps a tag FIFO so that in-order data_ok/rdata returns reach the requester that issued them.
- Sits between mycpu core ports and the external/bridge side.

Parameters:
- OUTSTANDING, 4, maximum accepted-but-unanswered requests; power of 2, ≥2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_req / inst_wr  in  1 / 1  instruction request, write flag
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_wstrb  in  4  byte strobes
- inst_addr / inst_wdata  in  ADDR_W / DATA_W  address, write data
- inst_addr_ok / inst_data_ok  out  1 / 1  request accepted, response valid
- inst_rdata  out  DATA_W  read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  same widths as inst_*  data-port request
- data_addr_ok / data_data_ok  out  1 / 1  data-port handshake
- data_rdata  out  DATA_W  read data
- mem_req / mem_wr  out  1 / 1  merged request
- mem_size / mem_wstrb  out  2 / 4  merged size, strobes
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  merged address, write data
- mem_addr_ok / mem_data_ok  in  1 / 1  slave handshake
- mem_rdata  in  DATA_W  slave read data

Behaviour:
- Protocol: SRAM-like. A request fires on req && addr_ok in the same cycle. A master holds req and all request fields stable until addr_ok. Responses arrive in acceptance order, one per data_ok.
- Grant and lock:
  - State IDLE: if data_req, owner=DATA; else if inst_req, owner=INST. The choice is combinational in the same cycle (data strictly prioritised).
  - If mem_req is high and mem_addr_ok is low, go to LOCKED with the owner registered.
  - LOCKED: the registered owner drives mem_*, whatever new requests appear.
  - Return to IDLE on mem_addr_ok.
- Request gating: mem_req = owner's req && !fifo_full && !reset.
  - mem_* fields mux from the owner.
  - When no request is active, mem_wr/size/wstrb/addr/wdata are 0.
- addr_ok passthrough: owner_addr_ok = mem_req && mem_addr_ok, in the same cycle. The non-owner's addr_ok is 0.
- Tag FIFO:
  - Depth OUTSTANDING, 1-bit entries (0=INST, 1=DATA).
  - Push owner on a handshake; pop head on mem_data_ok.
  - Pointers are log2(OUTSTANDING) bits and wrap; count is log2(OUTSTANDING)+1 bits.
- Response routing:
  - inst_data_ok = mem_data_ok && !empty && head==INST.
  - data_data_ok likewise with head==DATA.
  - inst_rdata and data_rdata both = mem_rdata (broadcast).
- Write acknowledgements are tagged and routed identically to reads.
- Simultaneous push and pop: both take effect and count is unchanged. This also holds when count==OUTSTANDING-1.
- Full: no new mem_req. A pop in the same cycle does not unblock it; acceptance resumes next cycle.
- Empty with mem_data_ok (slave protocol error): ignored. Both data_ok outputs stay 0 and the FIFO is unchanged.
- Reset (incl. mid-transaction):
  - Next cycle: FIFO empty, pointers/count 0, state IDLE.
  - While reset is high: mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok are 0.
  - In-flight responses are dropped; the slave is reset together with the arbiter.
- No request cancellation: a pipeline flush does not withdraw an issued or accepted request. The core discards unwanted responses itself.

Decomposition:
- Shared package cpu_bus_pkg:
  - requester IDs: REQ_INST=1'b0, REQ_DATA=1'b1
  - size encodings: SIZE_B=2'd0, SIZE_H=2'd1, SIZE_W=2'd2
  - arbiter state encoding: ARB_IDLE, ARB_LOCKED
- One sub-module: arb_tag_fifo. Parameter DEPTH; signals push, push_id, pop, head_id, full, empty.

Test Plan:
- Solo inst read: inst_req, addr 0x1C000000; mem_addr_ok=1 the same cycle; mem_data_ok 2 cycles later with rdata 0x02800404 -> inst_addr_ok in cycle 0; inst_data_ok=1 and inst_rdata=0x02800404 in cycle 2; data_data_ok stays 0.
- Contention: inst_req and data_req (store, addr 0x1C010000, wstrb 4'hF, wdata 0xDEADBEEF) in the same cycle with addr_ok=1 -> data granted first (mem_wdata=0xDEADBEEF); inst granted next cycle. Responses return as data_data_ok then inst_data_ok.
- Lock: inst_req granted with mem_addr_ok low for 3 cycles; data_req rises in cycle 1 -> mem_addr stays the inst address until addr_ok. Data is issued the cycle after that.
- Full: 4 inst reads accepted with no data_ok -> 5th request sees mem_req=0. Apply data_ok with a pending 5th request -> mem_req rises the next cycle. Pointers wrap correctly over 10 transactions.
- Interleave: requests I, D, I, D accepted; data_ok with rdata 1, 2, 3, 4 -> inst gets 1, 3 and data gets 2, 4. Simultaneous push and pop keeps count constant.
- Reset mid-flight: 2 outstanding requests, then reset for 1 cycle -> all handshake outputs 0 during reset. After reset FIFO is empty, and a stray mem_data_ok produces no data_ok.
